// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux with a break-before-make idle cycle on every handover.
// Defining MUX_ARB_TIMEOUT_EN adds a hold counter that forces an owner off after MAX_HOLD busy cycles when others wait.
//
// state | meaning
// IDLE  | no owner; gnt=0, sel holds the last owner; rotating search from ptr
// BUSY  | owner = sel; held while its req stays high

module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("mux_rr_arbiter: MAX_HOLD must be within 2..255");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] win, idx;
  logic       found;
  logic       force_rel;
  logic       timeout_d;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q;
`endif

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    force_rel = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    force_rel = (hold_q == 8'(MAX_HOLD - 1)) && (|(req & ~gnt_q));
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (!req[sel_q] || force_rel) begin
          // Same path for voluntary and forced release; the pulse only marks the forced one.
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = sel_q + 2'd1;
          timeout_d = req[sel_q] && force_rel;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_q != 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed per-cycle vectors push expected outputs, a negedge monitor compares.
// Test 5 expectations follow MUX_ARB_TIMEOUT_EN when the bench is compiled with it.

module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .sel(sel), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got {gnt,sel,valid,timeout}=%b, expected %b", name, act, expv);
  endfunction

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {gnt, sel, valid, timeout}, {e.gnt, e.sel, (e.gnt != 4'b0000), e.to});
      end
    end
  end

  // Drive req for this cycle and record what the outputs must show during it.
  task automatic row(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                     input logic to, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    req = r;
    e.gnt = g; e.sel = s; e.to = to; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
  endtask

  task automatic do_reset();
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("reset_async", {gnt, sel, valid, timeout}, 8'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset_initial", {gnt, sel, valid, timeout}, 8'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: idle
    for (int i = 0; i < 5; i++) row(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_idle");

    // 2: single requester 2
    row(4'b0100, 4'b0000, 2'd0, 1'b0, "t2_req");
    row(4'b0100, 4'b0100, 2'd2, 1'b0, "t2_gnt");
    row(4'b0100, 4'b0100, 2'd2, 1'b0, "t2_hold");
    row(4'b0000, 4'b0100, 2'd2, 1'b0, "t2_drop");
    row(4'b0000, 4'b0000, 2'd2, 1'b0, "t2_released");

    // 3: all four, rotation 0,1,2,3,0
    do_reset();
    row(4'b1111, 4'b0000, 2'd0, 1'b0, "t3_idle0");
    row(4'b1111, 4'b0001, 2'd0, 1'b0, "t3_g0a");
    row(4'b1111, 4'b0001, 2'd0, 1'b0, "t3_g0b");
    row(4'b1110, 4'b0001, 2'd0, 1'b0, "t3_g0c");
    row(4'b1111, 4'b0000, 2'd0, 1'b0, "t3_gap1");
    row(4'b1111, 4'b0010, 2'd1, 1'b0, "t3_g1a");
    row(4'b1111, 4'b0010, 2'd1, 1'b0, "t3_g1b");
    row(4'b1101, 4'b0010, 2'd1, 1'b0, "t3_g1c");
    row(4'b1111, 4'b0000, 2'd1, 1'b0, "t3_gap2");
    row(4'b1111, 4'b0100, 2'd2, 1'b0, "t3_g2a");
    row(4'b1111, 4'b0100, 2'd2, 1'b0, "t3_g2b");
    row(4'b1011, 4'b0100, 2'd2, 1'b0, "t3_g2c");
    row(4'b1111, 4'b0000, 2'd2, 1'b0, "t3_gap3");
    row(4'b1111, 4'b1000, 2'd3, 1'b0, "t3_g3a");
    row(4'b1111, 4'b1000, 2'd3, 1'b0, "t3_g3b");
    row(4'b0111, 4'b1000, 2'd3, 1'b0, "t3_g3c");
    row(4'b1111, 4'b0000, 2'd3, 1'b0, "t3_gap0");
    row(4'b1111, 4'b0001, 2'd0, 1'b0, "t3_g0_again");
    row(4'b0000, 4'b0001, 2'd0, 1'b0, "t3_g0_drop");
    row(4'b0000, 4'b0000, 2'd0, 1'b0, "t3_end");

    // 4: owner 3 releases, ptr wraps to 0 and beats 3; 1-cycle BUSY
    row(4'b1000, 4'b0000, 2'd0, 1'b0, "t4_req3");
    row(4'b1000, 4'b1000, 2'd3, 1'b0, "t4_g3");
    row(4'b0001, 4'b1000, 2'd3, 1'b0, "t4_g3_drop");
    row(4'b1001, 4'b0000, 2'd3, 1'b0, "t4_gap");
    row(4'b0000, 4'b0001, 2'd0, 1'b0, "t4_g0_wrap");
    row(4'b0000, 4'b0000, 2'd0, 1'b0, "t4_g0_rel");

    // transient non-owner request is never granted
    row(4'b0010, 4'b0000, 2'd0, 1'b0, "tx_req1");
    row(4'b0110, 4'b0010, 2'd1, 1'b0, "tx_g1_blip2");
    row(4'b0010, 4'b0010, 2'd1, 1'b0, "tx_g1");
    row(4'b0000, 4'b0010, 2'd1, 1'b0, "tx_g1_drop");
    row(4'b0000, 4'b0000, 2'd1, 1'b0, "tx_no_g2");
    row(4'b0000, 4'b0000, 2'd1, 1'b0, "tx_no_g2b");

    // 5: long hold by owner 0 with requester 1 waiting
    do_reset();
    row(4'b0001, 4'b0000, 2'd0, 1'b0, "t5_req0");
    for (int i = 0; i < 8; i++) row(4'b0011, 4'b0001, 2'd0, 1'b0, "t5_hold");
`ifdef MUX_ARB_TIMEOUT_EN
    row(4'b0011, 4'b0000, 2'd0, 1'b1, "t5_timeout");
    row(4'b0011, 4'b0010, 2'd1, 1'b0, "t5_g1");
    row(4'b0000, 4'b0010, 2'd1, 1'b0, "t5_g1_drop");
    row(4'b0000, 4'b0000, 2'd1, 1'b0, "t5_end");
`else
    row(4'b0011, 4'b0001, 2'd0, 1'b0, "t5_keep");
    row(4'b0011, 4'b0001, 2'd0, 1'b0, "t5_keep2");
    row(4'b0000, 4'b0001, 2'd0, 1'b0, "t5_drop");
    row(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_end");
`endif

    // 6: reset mid-BUSY with ptr=3, then ptr restarts at 0
    do_reset();
    row(4'b0100, 4'b0000, 2'd0, 1'b0, "t6_req2");
    row(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_g2");
    row(4'b0000, 4'b0100, 2'd2, 1'b0, "t6_g2_drop");
    row(4'b0100, 4'b0000, 2'd2, 1'b0, "t6_gap");
    row(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_g2_busy");
    do_reset();
    row(4'b1100, 4'b0000, 2'd0, 1'b0, "t6_after_rst");
    row(4'b1100, 4'b0100, 2'd2, 1'b0, "t6_ptr0_g2");
    row(4'b0000, 4'b0100, 2'd2, 1'b0, "t6_drop");
    row(4'b0000, 4'b0000, 2'd2, 1'b0, "t6_end");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
